// File: rtl/video_mnist_frame_gate.sv
// Frame gate for the segmentation core: forwards only whole camera frames.
// Ports: clk/reset, s_axi4s_* camera in, m_axi4s_* core out, s_wb_* registers.
module video_mnist_frame_gate #(
   parameter int                      TUSER_WIDTH       = 1,
   parameter int                      TDATA_WIDTH       = 8,
   parameter int                      Y_WIDTH           = 12,
   parameter int                      WB_ADR_WIDTH      = 8,
   parameter int                      WB_DAT_WIDTH      = 32,
   parameter logic [WB_DAT_WIDTH-1:0] CORE_ID           = 32'h527a_2310,
   parameter logic                    INIT_CTL_ENABLE   = 1'b1,
   parameter logic                    INIT_CTL_ONESHOT  = 1'b0,
   parameter int                      INIT_PARAM_HEIGHT = 480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
   input  logic                      s_axi4s_tlast,
   input  logic [TDATA_WIDTH-1:0]    s_axi4s_tdata,
   input  logic                      s_axi4s_tvalid,
   output logic                      s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
   output logic                      m_axi4s_tlast,
   output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
   output logic                      m_axi4s_tvalid,
   input  logic                      m_axi4s_tready,
   input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
   input  logic                      s_wb_we_i,
   input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
   input  logic                      s_wb_stb_i,
   output logic                      s_wb_ack_o
);

   localparam int SW = WB_DAT_WIDTH / 8;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_ID  = 'd0;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL = 'd1;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_STA = 'd2;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_HGT = 'd3;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_FRM = 'd4;
   localparam logic [WB_ADR_WIDTH-1:0] ADR_ERR = 'd5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      PASS     = 2'd2
   } state_t;

   state_t state, state_nx;

   logic                    ctl_enable, ctl_oneshot;
   logic [Y_WIDTH-1:0]      height_reg, height_act;
   logic [Y_WIDTH-1:0]      height_lat, height_use;
   logic [Y_WIDTH-1:0]      line_cnt, line_base;
   logic [WB_DAT_WIDTH-1:0] frame_cnt, err_cnt;
   logic [WB_DAT_WIDTH-1:0] wmask, rd;
   logic                    busy, waiting, pass;
   logic                    sof, accept, start_beat, err_sof;
   logic                    frame_end, stop;
   logic                    wb_wr, any_sel;
   logic [1:0]              ctl_new;
   logic [Y_WIDTH-1:0]      hgt_new;
   logic                    unused_ok;

   assign sof = s_axi4s_tuser[0];

   // zero-latency data path; dropped beats are always accepted
   assign m_axi4s_tuser  = s_axi4s_tuser;
   assign m_axi4s_tlast  = s_axi4s_tlast;
   assign m_axi4s_tdata  = s_axi4s_tdata;
   assign m_axi4s_tvalid = s_axi4s_tvalid & pass;
   assign s_axi4s_tready = pass ? m_axi4s_tready : 1'b1;

   assign accept     = s_axi4s_tvalid & s_axi4s_tready & pass;
   assign start_beat = accept & sof;
   assign err_sof    = start_beat & busy;

   // a zero HEIGHT still yields a one-line frame
   assign height_lat = (height_reg == '0) ? Y_WIDTH'(1) : height_reg;
   assign height_use = (start_beat & waiting) ? height_lat : height_act;
   assign line_base  = start_beat ? '0 : line_cnt;
   assign frame_end  = accept & s_axi4s_tlast
                     & (line_base == height_use - 1'b1);

   // a disable or oneshot only takes effect once the frame completes
   assign stop = ctl_oneshot | ~ctl_enable;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= INIT_CTL_ENABLE ? WAIT_SOF : IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (ctl_enable) state_nx = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (frame_end)
               state_nx = stop ? IDLE : WAIT_SOF;
            else if (start_beat)
               state_nx = PASS;
            else if (!ctl_enable)
               state_nx = IDLE;
         end
         PASS: begin
            if (frame_end)
               state_nx = stop ? IDLE : WAIT_SOF;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      waiting = 1'b0;
      unique case (state)
         WAIT_SOF: waiting = 1'b1;
         PASS:     busy    = 1'b1;
         default:  ;
      endcase
      pass = busy | (waiting & sof & ctl_enable);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         line_cnt   <= '0;
         height_act <= Y_WIDTH'(INIT_PARAM_HEIGHT);
      end else if (accept) begin
         if (start_beat & waiting)
            height_act <= height_lat;
         if (s_axi4s_tlast)
            line_cnt <= frame_end ? '0 : line_base + 1'b1;
         else
            line_cnt <= line_base;
      end
   end

   always_comb begin
      for (int i = 0; i < SW; i++)
         wmask[i*8 +: 8] = {8{s_wb_sel_i[i]}};
   end

   assign wb_wr   = s_wb_stb_i & s_wb_we_i;
   assign any_sel = |s_wb_sel_i;
   assign ctl_new = ({ctl_oneshot, ctl_enable} & ~wmask[1:0])
                  | (s_wb_dat_i[1:0] & wmask[1:0]);
   assign hgt_new = (height_reg & ~wmask[Y_WIDTH-1:0])
                  | (s_wb_dat_i[Y_WIDTH-1:0] & wmask[Y_WIDTH-1:0]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctl_enable  <= INIT_CTL_ENABLE;
         ctl_oneshot <= INIT_CTL_ONESHOT;
         height_reg  <= Y_WIDTH'(INIT_PARAM_HEIGHT);
         frame_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         if (wb_wr && s_wb_adr_i == ADR_CTL) begin
            ctl_enable  <= ctl_new[0];
            ctl_oneshot <= ctl_new[1];
         end
         if (frame_end && ctl_oneshot)
            ctl_enable <= 1'b0;
         if (wb_wr && s_wb_adr_i == ADR_HGT)
            height_reg <= hgt_new;
         if (wb_wr && any_sel && s_wb_adr_i == ADR_FRM)
            frame_cnt <= '0;
         else if (frame_end)
            frame_cnt <= frame_cnt + 1'b1;
         if (wb_wr && any_sel && s_wb_adr_i == ADR_ERR)
            err_cnt <= '0;
         else if (err_sof && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
      end
   end

   always_comb begin
      rd = '0;
      case (s_wb_adr_i)
         ADR_ID:  rd = CORE_ID;
         ADR_CTL: rd[1:0] = {ctl_oneshot, ctl_enable};
         ADR_STA: rd[2:0] = {waiting, ctl_enable, busy};
         ADR_HGT: rd[Y_WIDTH-1:0] = height_reg;
         ADR_FRM: rd = frame_cnt;
         ADR_ERR: rd = err_cnt;
         default: rd = '0;
      endcase
   end

   assign s_wb_dat_o = rd;
   assign s_wb_ack_o = s_wb_stb_i;

   assign unused_ok = &{1'b0,
                        s_wb_dat_i[WB_DAT_WIDTH-1:Y_WIDTH],
                        wmask[WB_DAT_WIDTH-1:Y_WIDTH]};

endmodule

// File: tb/tb_video_mnist_frame_gate.sv
// Self-checking bench for video_mnist_frame_gate.
// Frame-level reference model, per-cycle compare, beat scoreboard.
module tb_video_mnist_frame_gate;

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_FRAME = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [0:0]  s_tuser;
   logic        s_tlast;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_axi4s_tready;
   logic [0:0]  m_axi4s_tuser;
   logic        m_axi4s_tlast;
   logic [7:0]  m_axi4s_tdata;
   logic        m_axi4s_tvalid;
   logic        m_tready;
   logic [7:0]  wb_adr;
   logic [31:0] wb_dat;
   logic [31:0] s_wb_dat_o;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic        wb_stb;
   logic        s_wb_ack_o;

   video_mnist_frame_gate dut (
      .clk            (clk),
      .reset          (reset),
      .s_axi4s_tuser  (s_tuser),
      .s_axi4s_tlast  (s_tlast),
      .s_axi4s_tdata  (s_tdata),
      .s_axi4s_tvalid (s_tvalid),
      .s_axi4s_tready (s_axi4s_tready),
      .m_axi4s_tuser  (m_axi4s_tuser),
      .m_axi4s_tlast  (m_axi4s_tlast),
      .m_axi4s_tdata  (m_axi4s_tdata),
      .m_axi4s_tvalid (m_axi4s_tvalid),
      .m_axi4s_tready (m_tready),
      .s_wb_adr_i     (wb_adr),
      .s_wb_dat_i     (wb_dat),
      .s_wb_dat_o     (s_wb_dat_o),
      .s_wb_we_i      (wb_we),
      .s_wb_sel_i     (wb_sel),
      .s_wb_stb_i     (wb_stb),
      .s_wb_ack_o     (s_wb_ack_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          mode;
   int          lines_left;
   int          hframe;
   logic        en, os;
   logic [11:0] height;
   logic [31:0] frames, errs;
   logic [7:0]  q[$];

   int          n_mode, n_ll, n_hf;
   logic        n_en, n_os;
   logic [11:0] n_h;
   logic [31:0] n_fr, n_er;

   logic        hs;
   logic [31:0] last_rd;
   int          out_cnt;
   logic        first_tuser;
   logic        bp = 1'b0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(logic [7:0] a);
      case (a)
         8'd0: return 32'h527a_2310;
         8'd1: return {30'd0, os, en};
         8'd2: return {29'd0, mode == M_WAIT, en, mode == M_FRAME};
         8'd3: return {20'd0, height};
         8'd4: return frames;
         8'd5: return errs;
         default: return 32'd0;
      endcase
   endfunction

   task automatic cycle();
      logic mp, etr, acc, fend;
      @(negedge clk);
      hs = s_tvalid && s_axi4s_tready;
      last_rd = s_wb_dat_o;
      if (m_axi4s_tvalid && m_tready) begin
         out_cnt++;
         if (out_cnt == 1) first_tuser = m_axi4s_tuser[0];
      end
      if (reset) begin
         mp = (mode == M_FRAME) || (mode == M_WAIT && s_tuser[0] && en);
         etr = mp ? m_tready : 1'b1;
         check("s_tready", 32'(s_axi4s_tready), 32'(etr));
         check("m_tvalid", 32'(m_axi4s_tvalid), 32'(s_tvalid && mp));
         if (s_tvalid && mp) begin
            check("m_tdata", 32'(m_axi4s_tdata), 32'(s_tdata));
            check("m_tuser", 32'(m_axi4s_tuser), 32'(s_tuser));
            check("m_tlast", 32'(m_axi4s_tlast), 32'(s_tlast));
         end
         check("wb_ack", 32'(s_wb_ack_o), 32'(wb_stb));
         if (wb_stb && !wb_we)
            check("wb_rdata", s_wb_dat_o, model_rd(wb_adr));
         acc = s_tvalid && etr && mp;
         if (acc) q.push_back(s_tdata);
         if (m_axi4s_tvalid && m_tready) begin
            if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("sb_data", 32'(m_axi4s_tdata), 32'(q.pop_front()));
         end
         n_mode = mode; n_ll = lines_left; n_hf = hframe;
         n_en = en; n_os = os; n_h = height;
         n_fr = frames; n_er = errs;
         fend = 1'b0;
         if (acc) begin
            if (s_tuser[0]) begin
               if (mode == M_WAIT) begin
                  n_hf = (height == 12'd0) ? 1 : int'(height);
                  n_ll = n_hf;
               end else begin
                  if (errs != 32'hffff_ffff) n_er = errs + 1;
                  n_ll = hframe;
               end
            end
            n_mode = M_FRAME;
            if (s_tlast) begin
               n_ll = n_ll - 1;
               if (n_ll == 0) fend = 1'b1;
            end
         end else if (mode == M_IDLE && en) n_mode = M_WAIT;
         else if (mode == M_WAIT && !en) n_mode = M_IDLE;
         if (fend) begin
            n_fr = frames + 1;
            n_mode = (os || !en) ? M_IDLE : M_WAIT;
         end
         if (wb_stb && wb_we) begin
            case (wb_adr)
               8'd1: begin n_en = wb_dat[0]; n_os = wb_dat[1]; end
               8'd3: n_h = wb_dat[11:0];
               8'd4: n_fr = 0;
               8'd5: n_er = 0;
               default: ;
            endcase
         end
         if (fend && os) n_en = 1'b0;
      end
      @(posedge clk);
      if (!reset) begin
         mode = M_WAIT; en = 1'b1; os = 1'b0;
         height = 12'd480; hframe = 480; lines_left = 0;
         frames = 0; errs = 0; q.delete();
      end else begin
         mode = n_mode; lines_left = n_ll; hframe = n_hf;
         en = n_en; os = n_os; height = n_h;
         frames = n_fr; errs = n_er;
      end
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         if (bp) m_tready = 1'($urandom_range(1));
         cycle();
      end
   endtask

   task automatic wb_write(logic [7:0] a, logic [31:0] d);
      wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat = d; wb_sel = 4'hf;
      cycle();
      wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_read(logic [7:0] a, logic [31:0] exp, string nm);
      wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
      cycle();
      wb_stb = 1'b0;
      check(nm, last_rd, exp);
   endtask

   task automatic send_lines(int w, int l0, int l1, int off_line);
      int guard;
      for (int ln = l0; ln < l1; ln++) begin
         for (int x = 0; x < w; x++) begin
            if (ln == off_line && x == 0) begin
               s_tvalid = 1'b0;
               wb_write(8'd1, 32'd0);
            end
            if (bp && $urandom_range(3) == 0) begin
               s_tvalid = 1'b0;
               idle(1);
            end
            s_tvalid = 1'b1;
            s_tuser  = (ln == 0 && x == 0) ? 1'b1 : 1'b0;
            s_tlast  = (x == w - 1);
            s_tdata  = 8'($urandom);
            guard = 0;
            do begin
               if (bp) m_tready = 1'($urandom_range(1));
               cycle();
               guard++;
            end while (!hs && guard < 200);
            if (!hs) check("handshake_timeout", 32'd0, 32'd1);
         end
      end
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_out;
      int w;
      reset = 1'b0;
      s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0;
      m_tready = 1'b1;
      wb_adr = 8'd0; wb_dat = 32'd0; wb_we = 1'b0; wb_sel = 4'h0; wb_stb = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;

      wb_read(8'd0, 32'h527a_2310, "core_id");
      wb_read(8'd1, 32'd1, "ctl_reset");
      wb_read(8'd2, 32'd6, "status_reset");
      wb_read(8'd3, 32'd480, "height_reset");
      wb_read(8'd4, 32'd0, "frame_cnt_reset");
      wb_read(8'd6, 32'd0, "unmapped");

      // 1: single full frame
      wb_write(8'd3, 32'd4);
      out_cnt = 0;
      send_lines(8, 0, 4, -1);
      idle(2);
      check("t1_beats", 32'(out_cnt), 32'd32);
      check("t1_first_tuser", 32'(first_tuser), 32'd1);
      wb_read(8'd4, 32'd1, "t1_frame_cnt");
      wb_read(8'd2, 32'd6, "t1_status");

      // 2: join mid-frame
      wb_write(8'd4, 32'd0);
      out_cnt = 0;
      send_lines(8, 2, 4, -1);
      check("t2_dropped", 32'(out_cnt), 32'd0);
      send_lines(8, 0, 4, -1);
      idle(2);
      check("t2_beats", 32'(out_cnt), 32'd32);
      wb_read(8'd4, 32'd1, "t2_frame_cnt");

      // 3: oneshot
      wb_write(8'd4, 32'd0);
      wb_write(8'd1, 32'd3);
      out_cnt = 0;
      for (int f = 0; f < 3; f++) send_lines(8, 0, 4, -1);
      idle(2);
      check("t3_beats", 32'(out_cnt), 32'd32);
      wb_read(8'd1, 32'd2, "t3_ctl");
      wb_read(8'd4, 32'd1, "t3_frame_cnt");
      wb_read(8'd2, 32'd0, "t3_status");

      // 4: disable mid-frame
      wb_write(8'd1, 32'd1);
      wb_write(8'd4, 32'd0);
      idle(1);
      out_cnt = 0;
      send_lines(8, 0, 4, 1);
      check("t4_beats", 32'(out_cnt), 32'd32);
      send_lines(8, 0, 4, -1);
      idle(2);
      check("t4_after", 32'(out_cnt), 32'd32);
      wb_read(8'd2, 32'd0, "t4_status");
      wb_read(8'd4, 32'd1, "t4_frame_cnt");

      // 5: early SOF
      wb_write(8'd1, 32'd1);
      wb_write(8'd4, 32'd0);
      wb_write(8'd5, 32'd0);
      idle(1);
      out_cnt = 0;
      send_lines(8, 0, 2, -1);
      send_lines(8, 0, 4, -1);
      idle(2);
      check("t5_beats", 32'(out_cnt), 32'd48);
      wb_read(8'd5, 32'd1, "t5_err_cnt");
      wb_read(8'd4, 32'd1, "t5_frame_cnt");
      wb_read(8'd2, 32'd6, "t5_status");

      // HEIGHT==0 behaves as one line
      wb_write(8'd3, 32'd0);
      wb_write(8'd4, 32'd0);
      out_cnt = 0;
      send_lines(3, 0, 1, -1);
      send_lines(3, 0, 1, -1);
      idle(2);
      check("h0_beats", 32'(out_cnt), 32'd6);
      wb_read(8'd4, 32'd2, "h0_frame_cnt");

      // 6: random back-pressure
      wb_write(8'd3, 32'd3);
      wb_write(8'd4, 32'd0);
      out_cnt = 0;
      exp_out = 0;
      bp = 1'b1;
      for (int f = 0; f < 6; f++) begin
         w = $urandom_range(6, 1);
         exp_out += w * 3;
         send_lines(w, 0, 3, -1);
         idle($urandom_range(3));
      end
      bp = 1'b0;
      m_tready = 1'b1;
      idle(3);
      check("t6_beats", 32'(out_cnt), 32'(exp_out));
      check("t6_queue_empty", 32'(q.size()), 32'd0);
      wb_read(8'd4, 32'd6, "t6_frame_cnt");
      wb_read(8'd5, 32'd1, "t6_err_cnt");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
